// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the MEM16x8 port arbiter: requester indices, FSM
// encodings, default widths and the round-robin wrap helper.
package mem_port_arbiter_pkg;

  localparam int NREQ_DEF      = 3;
  localparam int AW_DEF        = 4;
  localparam int DW_DEF        = 8;
  localparam int MAX_BURST_DEF = 8;

  localparam int REQ_CTRL = 0;
  localparam int REQ_COMP = 1;
  localparam int REQ_DISP = 2;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_OWN  = 1'b1;

  typedef struct packed {
    logic [1:0] idx;
    logic       found;
  } pick_t;

  // Wraps idx into [0, n) assuming idx < 2*n, which is all a rotating scan needs.
  function automatic logic [1:0] rr_wrap(input int idx, input int n);
    int r;
    r = idx;
    if (r >= n) r = r - n;
    return r[1:0];
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester-side bus plus MEM16x8 pins of the port arbiter, bundled so the
// arbiter and its users share a single connection point.
interface mem_port_arbiter_if
  import mem_port_arbiter_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int AW   = AW_DEF,
  parameter int DW   = DW_DEF
);

  logic [NREQ-1:0]    req;
  logic [NREQ-1:0]    lock;
  logic [NREQ-1:0]    wr;
  logic [NREQ*AW-1:0] addr;
  logic [NREQ*DW-1:0] wdata;
  logic [NREQ-1:0]    gnt;
  logic [NREQ-1:0]    rvalid;
  logic [DW-1:0]      rdata;
  logic [1:0]         owner;
  logic               busy;

  logic               mem_wr;
  logic [AW-1:0]      mem_addr;
  logic [DW-1:0]      mem_din;
  logic [DW-1:0]      mem_dout;

  modport master (
    output req, lock, wr, addr, wdata, mem_dout,
    input  gnt, rvalid, rdata, owner, busy, mem_wr, mem_addr, mem_din
  );

  modport slave (
    input  req, lock, wr, addr, wdata, mem_dout,
    output gnt, rvalid, rdata, owner, busy, mem_wr, mem_addr, mem_din
  );

endinterface

// File: rtl/mem_port_arbiter_rr_pick.sv
// Combinational round-robin picker: first masked request at or after i_rr_ptr.
module mem_port_arbiter_rr_pick
  import mem_port_arbiter_pkg::*;
#(
  parameter int NREQ = NREQ_DEF
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [NREQ-1:0] i_mask,
  input  logic [1:0]      i_rr_ptr,
  output logic [1:0]      o_winner,
  output logic            o_found
);

  logic [NREQ-1:0] w_elig;
  logic [1:0]      w_idx;

  assign w_elig = i_req & i_mask;

  always_comb begin
    o_found  = 1'b0;
    o_winner = '0;
    w_idx    = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_idx = rr_wrap(int'(i_rr_ptr) + k, NREQ);
      if (!o_found && w_elig[w_idx]) begin
        o_found  = 1'b1;
        o_winner = w_idx;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing the single-port MEM16x8 among NREQ requesters,
// with capped locked bursts and 1-cycle tagged read return.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int NREQ      = NREQ_DEF,
  parameter int AW        = AW_DEF,
  parameter int DW        = DW_DEF,
  parameter int MAX_BURST = MAX_BURST_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  mem_port_arbiter_if.slave bus
);

  localparam int BCW = $clog2(MAX_BURST + 1);

  logic [0:0]      r_state;
  logic [1:0]      r_rr_ptr;
  logic [1:0]      r_owner;
  logic [BCW-1:0]  r_burst_cnt;
  logic [NREQ-1:0] r_rvalid_p1;
  logic [AW-1:0]   r_last_addr;

  logic [NREQ-1:0] w_owner_bit;
  logic [NREQ-1:0] w_mask;
  logic [NREQ-1:0] w_gnt_raw;
  logic [NREQ-1:0] w_gnt;
  logic            w_own_req;
  logic            w_own_lock;
  logic            w_cap;
  logic            w_others;
  logic            w_hold;
  logic            w_any;
  logic [1:0]      w_g;
  logic [AW-1:0]   w_sel_addr;
  logic [DW-1:0]   w_sel_din;
  pick_t           w_pick;

  assign w_owner_bit = NREQ'(1) << r_owner;
  assign w_own_req   = bus.req[r_owner];
  assign w_own_lock  = bus.lock[r_owner];
  assign w_cap       = (r_burst_cnt == BCW'(MAX_BURST));
  assign w_others    = |(bus.req & ~w_owner_bit);

  // The owner keeps the port only while it still requests and is under the cap;
  // every other case falls back to a normal arbitration in the same cycle.
  assign w_hold = (r_state == ST_OWN) && w_own_req && !w_cap;
  assign w_mask = ((r_state == ST_OWN) && w_cap && w_others) ? ~w_owner_bit : '1;

  mem_port_arbiter_rr_pick #(
    .NREQ (NREQ)
  ) u_rr_pick (
    .i_req    (bus.req),
    .i_mask   (w_mask),
    .i_rr_ptr (r_rr_ptr),
    .o_winner (w_pick.idx),
    .o_found  (w_pick.found)
  );

  always_comb begin
    w_gnt_raw = '0;
    w_g       = w_pick.idx;
    if (w_hold) begin
      w_gnt_raw = w_owner_bit;
      w_g       = r_owner;
    end else if (w_pick.found) begin
      w_gnt_raw = NREQ'(1) << w_pick.idx;
    end
  end

  assign w_gnt      = rst_n ? w_gnt_raw : '0;
  assign w_any      = |w_gnt;
  assign w_sel_addr = bus.addr[w_g*AW +: AW];
  assign w_sel_din  = bus.wdata[w_g*DW +: DW];

  assign bus.gnt      = w_gnt;
  assign bus.mem_wr   = w_any & bus.wr[w_g];
  assign bus.mem_addr = w_any ? w_sel_addr : r_last_addr;
  assign bus.mem_din  = w_sel_din;
  assign bus.rvalid   = r_rvalid_p1;
  assign bus.rdata    = bus.mem_dout;
  assign bus.owner    = r_owner;
  assign bus.busy     = (r_state == ST_OWN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_rr_ptr    <= '0;
      r_owner     <= '0;
      r_burst_cnt <= '0;
    end else if (w_hold) begin
      if (w_own_lock) begin
        r_burst_cnt <= r_burst_cnt + BCW'(1);
      end else begin
        r_state     <= ST_IDLE;
        r_owner     <= '0;
        r_burst_cnt <= '0;
      end
    end else if (w_pick.found) begin
      r_rr_ptr <= rr_wrap(int'(w_pick.idx) + 1, NREQ);
      if (bus.lock[w_pick.idx]) begin
        r_state     <= ST_OWN;
        r_owner     <= w_pick.idx;
        r_burst_cnt <= BCW'(1);
      end else begin
        r_state     <= ST_IDLE;
        r_owner     <= '0;
        r_burst_cnt <= '0;
      end
    end else begin
      r_state     <= ST_IDLE;
      r_owner     <= '0;
      r_burst_cnt <= '0;
    end
  end

  // Read-return stage: memory data appears one cycle after the grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rvalid_p1 <= '0;
    else        r_rvalid_p1 <= w_gnt & ~bus.wr;
  end

  always_ff @(posedge clk) begin
    if (w_any) r_last_addr <= w_sel_addr;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scenario bench for mem_port_arbiter with a MEM16x8 model and a read-data
// scoreboard filled from the expected grant of each driven cycle.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int NREQ = 3;
  localparam int AW   = 4;
  localparam int DW   = 8;

  typedef struct packed {
    logic [NREQ-1:0] rv;
    logic [DW-1:0]   rd;
  } sb_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  logic [DW-1:0] tb_mem  [16];
  logic [DW-1:0] ref_mem [16];
  sb_t           sb_q [$];

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus ();

  mem_port_arbiter #(
    .NREQ      (NREQ),
    .AW        (AW),
    .DW        (DW),
    .MAX_BURST (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always @(posedge clk) begin
    if (bus.mem_wr) tb_mem[bus.mem_addr] <= bus.mem_din;
    bus.mem_dout <= tb_mem[bus.mem_addr];
  end

  task automatic set_port(input int i, input logic r, input logic l, input logic w,
                          input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.req[i]             = r;
    bus.lock[i]            = l;
    bus.wr[i]              = w;
    bus.addr[i*AW +: AW]   = a;
    bus.wdata[i*DW +: DW]  = d;
  endtask

  task automatic clear_ports();
    bus.req   = '0;
    bus.lock  = '0;
    bus.wr    = '0;
    bus.addr  = '0;
    bus.wdata = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_ports();
    sb_q.delete();
    sb_q.push_back(sb_t'(0));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Pops this cycle's expected read return and queues the next one from the
  // grant the bench expects for the stimulus currently driven.
  task automatic sb_cycle(input logic [NREQ-1:0] exp_gnt, output sb_t cur);
    sb_t           nxt;
    logic [AW-1:0] a;
    nxt = sb_t'(0);
    if (sb_q.size() > 0) cur = sb_q.pop_front();
    else                 cur = sb_t'(0);
    for (int i = 0; i < NREQ; i++) begin
      if (exp_gnt[i]) begin
        a = bus.addr[i*AW +: AW];
        if (bus.wr[i]) ref_mem[a] = bus.wdata[i*DW +: DW];
        else begin
          nxt.rv = exp_gnt;
          nxt.rd = ref_mem[a];
        end
      end
    end
    sb_q.push_back(nxt);
  endtask

  task automatic test_reset();
    sb_t cur;
    rst_n = 1'b0;
    set_port(0, 1'b1, 1'b1, 1'b1, 4'd1, 8'h11);
    set_port(1, 1'b1, 1'b0, 1'b0, 4'd2, 8'h00);
    set_port(2, 1'b1, 1'b0, 1'b0, 4'd3, 8'h00);
    @(negedge clk);
    n_checks++; if (bus.gnt !== 3'b000) begin n_fail++; $display("FAIL rst_gnt: got %b, want 000", bus.gnt); end
    n_checks++; if (bus.mem_wr !== 1'b0) begin n_fail++; $display("FAIL rst_mem_wr: got %b, want 0", bus.mem_wr); end
    n_checks++; if (bus.rvalid !== 3'b000) begin n_fail++; $display("FAIL rst_rvalid: got %b, want 000", bus.rvalid); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b, want 0", bus.busy); end
    n_checks++; if (bus.owner !== 2'd0) begin n_fail++; $display("FAIL rst_owner: got %0d, want 0", bus.owner); end
    do_reset();
    @(negedge clk);
    sb_cycle(3'b000, cur);
    n_checks++; if (bus.rvalid !== cur.rv) begin n_fail++; $display("FAIL rst_idle_rvalid: got %b, want %b", bus.rvalid, cur.rv); end
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    sb_t cur;
    do_reset();
    set_port(0, 1'b1, 1'b0, 1'b1, 4'd3, 8'h5A);
    @(negedge clk);
    sb_cycle(3'b001, cur);
    n_checks++; if (bus.gnt !== 3'b001) begin n_fail++; $display("FAIL single_wr_gnt: got %b, want 001", bus.gnt); end
    n_checks++; if (bus.mem_wr !== 1'b1) begin n_fail++; $display("FAIL single_mem_wr: got %b, want 1", bus.mem_wr); end
    n_checks++; if (bus.mem_addr !== 4'd3) begin n_fail++; $display("FAIL single_mem_addr: got %0d, want 3", bus.mem_addr); end
    n_checks++; if (bus.mem_din !== 8'h5A) begin n_fail++; $display("FAIL single_mem_din: got %h, want 5a", bus.mem_din); end
    @(posedge clk); #1;
    set_port(0, 1'b0, 1'b0, 1'b0, 4'd0, 8'h00);
    set_port(1, 1'b1, 1'b0, 1'b0, 4'd3, 8'h00);
    @(negedge clk);
    sb_cycle(3'b010, cur);
    n_checks++; if (bus.gnt !== 3'b010) begin n_fail++; $display("FAIL single_rd_gnt: got %b, want 010", bus.gnt); end
    n_checks++; if (bus.mem_wr !== 1'b0) begin n_fail++; $display("FAIL single_rd_mem_wr: got %b, want 0", bus.mem_wr); end
    @(posedge clk); #1;
    clear_ports();
    @(negedge clk);
    sb_cycle(3'b000, cur);
    n_checks++; if (bus.gnt !== 3'b000) begin n_fail++; $display("FAIL single_idle_gnt: got %b, want 000", bus.gnt); end
    n_checks++; if (bus.rvalid !== cur.rv) begin n_fail++; $display("FAIL single_rvalid: got %b, want %b", bus.rvalid, cur.rv); end
    if (cur.rv != '0) begin
      n_checks++; if (bus.rdata !== cur.rd) begin n_fail++; $display("FAIL single_rdata: got %h, want %h", bus.rdata, cur.rd); end
    end
    n_checks++; if (bus.mem_addr !== 4'd3) begin n_fail++; $display("FAIL single_addr_hold: got %0d, want 3", bus.mem_addr); end
    @(posedge clk); #1;
  endtask

  task automatic test_round_robin();
    sb_t             cur;
    logic [NREQ-1:0] exp;
    do_reset();
    set_port(0, 1'b1, 1'b0, 1'b0, 4'd3, 8'h00);
    set_port(1, 1'b1, 1'b0, 1'b0, 4'd1, 8'h00);
    set_port(2, 1'b1, 1'b0, 1'b0, 4'd2, 8'h00);
    for (int c = 0; c < 7; c++) begin
      if (c == 6) clear_ports();
      exp = (c == 6) ? 3'b000 : NREQ'(1) << (c % 3);
      @(negedge clk);
      sb_cycle(exp, cur);
      n_checks++; if (bus.gnt !== exp) begin n_fail++; $display("FAIL rr_gnt c%0d: got %b, want %b", c, bus.gnt, exp); end
      n_checks++; if (bus.rvalid !== cur.rv) begin n_fail++; $display("FAIL rr_rvalid c%0d: got %b, want %b", c, bus.rvalid, cur.rv); end
      if (cur.rv != '0) begin
        n_checks++; if (bus.rdata !== cur.rd) begin n_fail++; $display("FAIL rr_rdata c%0d: got %h, want %h", c, bus.rdata, cur.rd); end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_locked_burst();
    sb_t             cur;
    logic [NREQ-1:0] exp;
    logic            exp_busy;
    do_reset();
    set_port(0, 1'b1, 1'b0, 1'b0, 4'd3, 8'h00);
    @(negedge clk);
    sb_cycle(3'b001, cur);
    n_checks++; if (bus.gnt !== 3'b001) begin n_fail++; $display("FAIL burst_pre_gnt: got %b, want 001", bus.gnt); end
    @(posedge clk); #1;
    set_port(1, 1'b1, 1'b1, 1'b0, 4'd5, 8'h00);
    for (int c = 0; c < 12; c++) begin
      exp      = (c == 8) ? 3'b001 : 3'b010;
      exp_busy = (c >= 1 && c <= 8) || (c >= 10);
      @(negedge clk);
      sb_cycle(exp, cur);
      n_checks++; if (bus.gnt !== exp) begin n_fail++; $display("FAIL burst_gnt c%0d: got %b, want %b", c, bus.gnt, exp); end
      n_checks++; if (bus.busy !== exp_busy) begin n_fail++; $display("FAIL burst_busy c%0d: got %b, want %b", c, bus.busy, exp_busy); end
      n_checks++; if (bus.rvalid !== cur.rv) begin n_fail++; $display("FAIL burst_rvalid c%0d: got %b, want %b", c, bus.rvalid, cur.rv); end
      if (cur.rv != '0) begin
        n_checks++; if (bus.rdata !== cur.rd) begin n_fail++; $display("FAIL burst_rdata c%0d: got %h, want %h", c, bus.rdata, cur.rd); end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_early_release();
    sb_t        cur;
    logic [2:0] eg [7];
    logic [6:0] eb;
    logic [1:0] eo [7];
    eg = '{3'b010, 3'b010, 3'b010, 3'b100, 3'b100, 3'b100, 3'b000};
    eb = 7'b0111110;
    eo = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd0};
    do_reset();
    for (int c = 0; c < 7; c++) begin
      set_port(1, c < 3, c < 3, 1'b0, 4'd3, 8'h00);
      set_port(2, c < 6, c < 5, 1'b0, 4'd3, 8'h00);
      @(negedge clk);
      sb_cycle(eg[c], cur);
      n_checks++; if (bus.gnt !== eg[c]) begin n_fail++; $display("FAIL early_gnt c%0d: got %b, want %b", c, bus.gnt, eg[c]); end
      n_checks++; if (bus.busy !== eb[c]) begin n_fail++; $display("FAIL early_busy c%0d: got %b, want %b", c, bus.busy, eb[c]); end
      n_checks++; if (bus.owner !== eo[c]) begin n_fail++; $display("FAIL early_owner c%0d: got %0d, want %0d", c, bus.owner, eo[c]); end
      n_checks++; if (bus.rvalid !== cur.rv) begin n_fail++; $display("FAIL early_rvalid c%0d: got %b, want %b", c, bus.rvalid, cur.rv); end
      if (cur.rv != '0) begin
        n_checks++; if (bus.rdata !== cur.rd) begin n_fail++; $display("FAIL early_rdata c%0d: got %h, want %h", c, bus.rdata, cur.rd); end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid_burst();
    sb_t cur;
    do_reset();
    set_port(1, 1'b1, 1'b1, 1'b0, 4'd3, 8'h00);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      sb_cycle(3'b010, cur);
      n_checks++; if (bus.gnt !== 3'b010) begin n_fail++; $display("FAIL midrst_gnt c%0d: got %b, want 010", c, bus.gnt); end
      n_checks++; if (bus.rvalid !== cur.rv) begin n_fail++; $display("FAIL midrst_rvalid c%0d: got %b, want %b", c, bus.rvalid, cur.rv); end
      if (c < 3) begin
        @(posedge clk); #1;
      end
    end
    rst_n = 1'b0;
    #1;
    n_checks++; if (bus.gnt !== 3'b000) begin n_fail++; $display("FAIL midrst_async_gnt: got %b, want 000", bus.gnt); end
    n_checks++; if (bus.rvalid !== 3'b000) begin n_fail++; $display("FAIL midrst_async_rvalid: got %b, want 000", bus.rvalid); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL midrst_async_busy: got %b, want 0", bus.busy); end
    n_checks++; if (bus.mem_wr !== 1'b0) begin n_fail++; $display("FAIL midrst_async_mem_wr: got %b, want 0", bus.mem_wr); end
    do_reset();
    set_port(1, 1'b1, 1'b0, 1'b0, 4'd3, 8'h00);
    set_port(2, 1'b1, 1'b0, 1'b0, 4'd3, 8'h00);
    @(negedge clk);
    sb_cycle(3'b010, cur);
    n_checks++; if (bus.gnt !== 3'b010) begin n_fail++; $display("FAIL midrst_first_gnt: got %b, want 010", bus.gnt); end
    @(posedge clk); #1;
    set_port(1, 1'b0, 1'b0, 1'b0, 4'd0, 8'h00);
    @(negedge clk);
    sb_cycle(3'b100, cur);
    n_checks++; if (bus.gnt !== 3'b100) begin n_fail++; $display("FAIL midrst_second_gnt: got %b, want 100", bus.gnt); end
    n_checks++; if (bus.rdata !== cur.rd || bus.rvalid !== cur.rv) begin n_fail++; $display("FAIL midrst_rdata: got %b/%h, want %b/%h", bus.rvalid, bus.rdata, cur.rv, cur.rd); end
    @(posedge clk); #1;
  endtask

  task automatic test_hazard();
    sb_t cur;
    do_reset();
    set_port(0, 1'b1, 1'b0, 1'b1, 4'd15, 8'hFF);
    @(negedge clk);
    sb_cycle(3'b001, cur);
    n_checks++; if (bus.gnt !== 3'b001) begin n_fail++; $display("FAIL hazard_wr_gnt: got %b, want 001", bus.gnt); end
    @(posedge clk); #1;
    set_port(0, 1'b0, 1'b0, 1'b0, 4'd0, 8'h00);
    set_port(2, 1'b1, 1'b0, 1'b0, 4'd15, 8'h00);
    @(negedge clk);
    sb_cycle(3'b100, cur);
    n_checks++; if (bus.gnt !== 3'b100) begin n_fail++; $display("FAIL hazard_rd_gnt: got %b, want 100", bus.gnt); end
    @(posedge clk); #1;
    clear_ports();
    @(negedge clk);
    sb_cycle(3'b000, cur);
    n_checks++; if (bus.rvalid !== cur.rv) begin n_fail++; $display("FAIL hazard_rvalid: got %b, want %b", bus.rvalid, cur.rv); end
    n_checks++; if (bus.rdata !== 8'hFF) begin n_fail++; $display("FAIL hazard_rdata: got %h, want ff", bus.rdata); end
    @(posedge clk); #1;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      tb_mem[i]  = '0;
      ref_mem[i] = '0;
    end
    clear_ports();
    test_reset();
    test_single();
    test_round_robin();
    test_locked_burst();
    test_early_release();
    test_reset_mid_burst();
    test_hazard();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port MEM16x8 between up to NREQ requesters: controller load writes, dot-product operand reads, and a display/debug readback port.
- Replaces the static mode_compute address/write mux in the top level.
- Grants one access per cycle, round-robin among requesters.
- Supports locked bursts capped at MAX_BURST beats and returns read data with 1-cycle latency, tagged per requester.

Parameters:
- NREQ, 3, number of requesters (index 0 = controller, 1 = computation, 2 = display).
- AW, 4, address width.
- DW, 8, data width.
- MAX_BURST, 8, maximum consecutive beats while locked before forced release.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req  in  NREQ  per-requester access request for the current cycle.
- lock  in  NREQ  requester asks to keep ownership after this beat.
- wr  in  NREQ  1 = write, 0 = read, qualified by req.
- addr  in  NREQ*AW  flattened addresses; requester i uses bits [i*AW +: AW].
- wdata  in  NREQ*DW  flattened write data.
- gnt  out  NREQ  one-hot (or zero), combinational; access completes this cycle.
- rvalid  out  NREQ  registered; pulses the cycle after a granted read.
- rdata  out  DW  equals mem_dout; meaningful when any rvalid is high.
- mem_wr  out  1  to MEM16x8 WR.
- mem_addr  out  AW  to MEM16x8 ADDR.
- mem_din  out  DW  to MEM16x8 DATA_IN.
- mem_dout  in  DW  from MEM16x8 DATA_OUT; valid 1 cycle after a read address is sampled.
- owner  out  2  current burst owner index, registered; 0 when idle.
- busy  out  1  1 while in OWN state.

Behaviour:
- Reset (async, rst_n=0):
  - state = IDLE, rr_ptr = 0, burst_cnt = 0, owner = 0.
  - rvalid = 0, busy = 0.
  - gnt = 0 and mem_wr = 0 while reset is asserted.
- Memory drive:
  - mem_addr, mem_din and wr come from the granted requester; mem_wr = wr[g] & |gnt.
  - With no grant, mem_wr = 0 and mem_addr holds the last granted address (registered copy).
- IDLE:
  - Grant the first i with req[i]=1, scanning rr_ptr, rr_ptr+1, ... mod NREQ.
  - On grant: rr_ptr <= (winner+1) mod NREQ.
  - If lock[winner]=1, go to OWN with owner = winner and burst_cnt = 1.
- OWN:
  - req[owner]=1, lock[owner]=1 and burst_cnt < MAX_BURST: grant owner, burst_cnt++.
  - req[owner]=1, lock[owner]=0: grant owner as the final beat, go to IDLE.
  - req[owner]=0: release immediately and arbitrate this same cycle using the IDLE rule. No bubble cycle.
  - burst_cnt == MAX_BURST: forced release. Arbitrate as IDLE but skip owner if any other req is high. If only the owner requests, it starts a new burst with burst_cnt = 1.
- Read return:
  - For a granted read by i in cycle t, rvalid[i] = 1 in cycle t+1; all other rvalid bits = 0.
  - Back-to-back reads give contiguous rvalid pulses.
- Write: takes effect at the grant edge. A read of the same address in the next cycle returns the new value.
- Ungranted requesters must hold req, wr, addr and wdata stable until granted. The arbiter never drops a request.
- Fairness: with all requesters continuously active, no requester waits more than (NREQ-1)*MAX_BURST cycles.
- Requests with out-of-range parameters are not checked. NREQ is limited to ≤ 4 because the owner port is 2 bits wide.

Decomposition:
- Shared package: requester index constants (REQ_CTRL=0, REQ_COMP=1, REQ_DISP=2), state encodings (IDLE, OWN), and the AW/DW defaults.
- One natural sub-module: rr_pick. It is combinational and takes req, a mask and rr_ptr, returning winner index and found.

Test Plan:
- Single requester: req[0]=1, wr=1, addr=3, wdata=0x5A, then req[1] reads addr 3 → gnt[0] in cycle 0; gnt[1] in cycle 1; rvalid[1]=1 with rdata=0x5A in cycle 2.
- Round-robin: req=3'b111 all unlocked for 6 cycles from reset → grant order 0,1,2,0,1,2.
- Locked burst: req[1]=1 and lock[1]=1 for 12 cycles, req[0]=1 throughout → gnt[1] for 8 cycles, then gnt[0] for 1 cycle, then gnt[1] resumes.
- Early release: owner 1 locked drops req after 3 beats while req[2]=1 → gnt[2] in the very next cycle with no idle gap; busy follows the new lock state.
- Reset mid-burst: assert rst_n=0 during beat 4 of a locked read burst → gnt, rvalid and busy go to 0 immediately. After release, the first grant goes to the lowest requesting index (rr_ptr=0).
- Write/read hazard: req[0] writes 0xFF to addr 15 in cycle t, req[2] reads addr 15 in cycle t+1 → rvalid[2] in t+2 with rdata=0xFF.
